// File: rtl/pacman_pkg.sv
// Shared types and constants for the player and ghost logic.
package pacman_pkg;

    // One-hot movement direction, same encoding as the ghost direction logic.
    typedef enum logic [3:0] {
        DIR_NONE  = 4'b0000,
        DIR_LEFT  = 4'b0001,
        DIR_RIGHT = 4'b0010,
        DIR_UP    = 4'b0100,
        DIR_DOWN  = 4'b1000
    } dir_t;

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_CAUGHT = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    // USB HID keycodes.
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    // Map a keycode to a direction; unknown codes (including 0) keep the current one.
    function automatic dir_t key_to_dir(input logic [7:0] key, input dir_t cur);
        dir_t d;
        case (key)
            KEY_A:   d = DIR_LEFT;
            KEY_D:   d = DIR_RIGHT;
            KEY_W:   d = DIR_UP;
            KEY_S:   d = DIR_DOWN;
            default: d = cur;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pacman_collide.sv
// Overlap test between two square sprites given centres and sizes.
module pacman_collide (
    input  logic [9:0] a_x,
    input  logic [9:0] a_y,
    input  logic [9:0] a_s,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    input  logic [9:0] b_s,
    output logic       hit
);

    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] thr;

    // Absolute centre distances against the combined half-extent, all 11-bit unsigned.
    always_comb begin
        dx  = (a_x >= b_x) ? ({1'b0, a_x} - {1'b0, b_x}) : ({1'b0, b_x} - {1'b0, a_x});
        dy  = (a_y >= b_y) ? ({1'b0, a_y} - {1'b0, b_y}) : ({1'b0, b_y} - {1'b0, a_y});
        thr = ({1'b0, a_s} + {1'b0, b_s}) >> 1;
        hit = (dx < thr) && (dy < thr);
    end

endmodule

// File: rtl/pacman_player.sv
// Player sprite: keyboard-steered movement, ghost capture, lives and game-over.
module pacman_player
    import pacman_pkg::*;
#(
    parameter int unsigned X_MIN         = 0,
    parameter int unsigned X_MAX         = 639,
    parameter int unsigned Y_MIN         = 0,
    parameter int unsigned Y_MAX         = 479,
    parameter int unsigned STEP          = 1,
    parameter int unsigned BALL_SIZE     = 8,
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned FREEZE_FRAMES = 60
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic [9:0] Start_X,
    input  logic [9:0] Start_Y,
    input  logic [9:0] GhostX,
    input  logic [9:0] GhostY,
    input  logic [9:0] GhostS,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] BallS,
    output logic       Over,
    output logic [1:0] Lives,
    output logic       Caught
);

    localparam logic [10:0] XMIN11   = 11'(X_MIN);
    localparam logic [10:0] XMAX11   = 11'(X_MAX);
    localparam logic [10:0] YMIN11   = 11'(Y_MIN);
    localparam logic [10:0] YMAX11   = 11'(Y_MAX);
    localparam logic [10:0] STEP11   = 11'(STEP);
    localparam logic [10:0] SIZE11   = 11'(BALL_SIZE);
    localparam logic [9:0]  STEP10   = 10'(STEP);
    localparam logic [1:0]  LIVES0   = 2'(LIVES_INIT);
    localparam logic [15:0] FREEZE_M1 = 16'(FREEZE_FRAMES - 1);

    state_t      state_q, state_d;
    dir_t        dir_q, dir_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [1:0]  lives_q, lives_d;
    logic [15:0] timer_q, timer_d;
    logic        over_q, over_d;
    logic        caught_q, caught_d;
    logic        hit;

    logic [10:0] x11;
    logic [10:0] y11;

    assign x11 = {1'b0, x_q};
    assign y11 = {1'b0, y_q};

    pacman_collide u_collide (
        .a_x (x_q),
        .a_y (y_q),
        .a_s (10'(BALL_SIZE)),
        .b_x (GhostX),
        .b_y (GhostY),
        .b_s (GhostS),
        .hit (hit)
    );

    // State register; async reset reloads the current spawn point.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_PLAY;
            dir_q    <= DIR_NONE;
            x_q      <= Start_X;
            y_q      <= Start_Y;
            lives_q  <= LIVES0;
            timer_q  <= '0;
            over_q   <= 1'b0;
            caught_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            x_q      <= x_d;
            y_q      <= y_d;
            lives_q  <= lives_d;
            timer_q  <= timer_d;
            over_q   <= over_d;
            caught_q <= caught_d;
        end
    end

    // Next-state logic: capture beats movement; movement uses last frame's direction.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        x_d      = x_q;
        y_d      = y_q;
        lives_d  = lives_q;
        timer_d  = timer_q;
        caught_d = 1'b0;
        case (state_q)
            ST_PLAY: begin
                if (hit) begin
                    caught_d = 1'b1;
                    if (lives_q > 2'd1) begin
                        state_d = ST_CAUGHT;
                        lives_d = lives_q - 2'd1;
                        timer_d = FREEZE_M1;
                        x_d     = Start_X;
                        y_d     = Start_Y;
                        dir_d   = DIR_NONE;
                    end else begin
                        state_d = ST_OVER;
                        lives_d = '0;
                    end
                end else begin
                    dir_d = key_to_dir(keycode, dir_q);
                    case (dir_q)
                        DIR_RIGHT: if (x11 + SIZE11 + STEP11 <= XMAX11) x_d = x_q + STEP10;
                        DIR_LEFT:  if (x11 >= XMIN11 + SIZE11 + STEP11) x_d = x_q - STEP10;
                        DIR_DOWN:  if (y11 + SIZE11 + STEP11 <= YMAX11) y_d = y_q + STEP10;
                        DIR_UP:    if (y11 >= YMIN11 + SIZE11 + STEP11) y_d = y_q - STEP10;
                        default: ;
                    endcase
                end
            end
            ST_CAUGHT: begin
                // The release edge already samples the key so motion starts on the next frame.
                if (timer_q == '0) begin
                    state_d = ST_PLAY;
                    dir_d   = key_to_dir(keycode, dir_q);
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_OVER: begin
                if (keycode == KEY_ENTER) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES0;
                    x_d     = Start_X;
                    y_d     = Start_Y;
                    dir_d   = DIR_NONE;
                end
            end
            default: state_d = ST_PLAY;
        endcase
        over_d = (state_d == ST_OVER);
    end

    assign BallX  = x_q;
    assign BallY  = y_q;
    assign BallS  = 10'(BALL_SIZE);
    assign Over   = over_q;
    assign Lives  = lives_q;
    assign Caught = caught_q;

endmodule

// File: tb/tb_pacman_player.sv
// Directed self-checking bench for pacman_player.
module tb_pacman_player;

    logic       frame_clk = 1'b0;
    logic       Reset_n   = 1'b1;
    logic [7:0] keycode   = '0;
    logic [9:0] Start_X   = 10'd320;
    logic [9:0] Start_Y   = 10'd240;
    logic [9:0] GhostX    = 10'd100;
    logic [9:0] GhostY    = 10'd100;
    logic [9:0] GhostS    = 10'd16;
    logic [9:0] BallX, BallY, BallS;
    logic       Over, Caught;
    logic [1:0] Lives;

    int tests = 0;
    int fails = 0;

    pacman_player #(
        .X_MIN(0), .X_MAX(639), .Y_MIN(0), .Y_MAX(479), .STEP(1),
        .BALL_SIZE(8), .LIVES_INIT(3), .FREEZE_FRAMES(60)
    ) dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycode   (keycode),
        .Start_X   (Start_X),
        .Start_Y   (Start_Y),
        .GhostX    (GhostX),
        .GhostY    (GhostY),
        .GhostS    (GhostS),
        .BallX     (BallX),
        .BallY     (BallY),
        .BallS     (BallS),
        .Over      (Over),
        .Lives     (Lives),
        .Caught    (Caught)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] key;
        logic [9:0] gx;
        logic [9:0] gy;
        int         ex;
        int         ey;
        int         elives;
        int         ecaught;
        int         eover;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        @(posedge frame_clk);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic ghost_far();
        GhostX = 10'd100;
        GhostY = 10'd100;
    endtask

    initial begin
        vecs[0]  = '{8'h1A, 10'd100, 10'd100, 320, 240, 3, 0, 0};
        vecs[1]  = '{8'h00, 10'd100, 10'd100, 320, 239, 3, 0, 0};
        vecs[2]  = '{8'h2C, 10'd100, 10'd100, 320, 238, 3, 0, 0};
        vecs[3]  = '{8'h04, 10'd100, 10'd100, 320, 237, 3, 0, 0};
        vecs[4]  = '{8'h00, 10'd100, 10'd100, 319, 237, 3, 0, 0};
        vecs[5]  = '{8'h16, 10'd100, 10'd100, 318, 237, 3, 0, 0};
        vecs[6]  = '{8'h00, 10'd100, 10'd100, 318, 238, 3, 0, 0};
        vecs[7]  = '{8'h07, 10'd100, 10'd100, 318, 239, 3, 0, 0};
        vecs[8]  = '{8'h00, 10'd100, 10'd100, 319, 239, 3, 0, 0};
        vecs[9]  = '{8'h00, 10'd325, 10'd239, 320, 240, 2, 1, 0};
        vecs[10] = '{8'h00, 10'd100, 10'd100, 320, 240, 2, 0, 0};

        // Reset state
        #3;
        do_reset();
        chk("reset_x", BallX, 320);
        chk("reset_y", BallY, 240);
        chk("reset_lives", Lives, 3);
        chk("reset_over", Over, 0);
        chk("reset_caught", Caught, 0);
        chk("ball_s", BallS, 8);

        // Table: direction decode, persistence, unknown key, capture
        for (int i = 0; i < 11; i++) begin
            keycode = vecs[i].key;
            GhostX  = vecs[i].gx;
            GhostY  = vecs[i].gy;
            step();
            chk($sformatf("vec%0d_x", i), BallX, vecs[i].ex);
            chk($sformatf("vec%0d_y", i), BallY, vecs[i].ey);
            chk($sformatf("vec%0d_lives", i), Lives, vecs[i].elives);
            chk($sformatf("vec%0d_caught", i), Caught, vecs[i].ecaught);
            chk($sformatf("vec%0d_over", i), Over, vecs[i].eover);
        end
        keycode = '0;

        // Key latency and persistence; Start change does not move a live player
        ghost_far();
        do_reset();
        keycode = 8'h07;
        repeat (10) step();
        chk("d10_x", BallX, 329);
        keycode = 8'h00;
        repeat (5) step();
        chk("persist_x", BallX, 334);
        Start_X = 10'd0;
        step();
        chk("start_change_x", BallX, 335);
        Start_X = 10'd320;

        // Right boundary
        Start_X = 10'd630;
        do_reset();
        chk("bound_start_x", BallX, 630);
        keycode = 8'h07;
        repeat (20) step();
        chk("right_bound_x", BallX, 631);
        // Top boundary
        Start_X = 10'd320;
        Start_Y = 10'd12;
        keycode = 8'h00;
        do_reset();
        keycode = 8'h1A;
        repeat (20) step();
        chk("top_bound_y", BallY, 8);
        Start_Y = 10'd240;
        keycode = 8'h00;

        // Capture with D on the same edge, keys held through the freeze
        do_reset();
        GhostX = 10'd322;
        GhostY = 10'd243;
        keycode = 8'h07;
        step();
        chk("cap_caught", Caught, 1);
        chk("cap_lives", Lives, 2);
        chk("cap_x", BallX, 320);
        ghost_far();
        for (int k = 1; k <= 60; k++) begin
            step();
            chk($sformatf("freeze%0d_x", k), BallX, 320);
        end
        chk("freeze_caught_low", Caught, 0);
        step();
        chk("resume61_x", BallX, 321);

        // Direction is NONE after respawn even if D was pressed on the capture edge
        do_reset();
        GhostX = 10'd320;
        GhostY = 10'd240;
        keycode = 8'h07;
        step();
        chk("cap2_caught", Caught, 1);
        keycode = 8'h00;
        ghost_far();
        repeat (63) step();
        chk("dir_none_x", BallX, 320);
        chk("dir_none_y", BallY, 240);
        keycode = 8'h00;

        // Three captures to game over, then Enter restarts
        do_reset();
        GhostX = 10'd320;
        GhostY = 10'd240;
        step();
        chk("c1_caught", Caught, 1);
        chk("c1_lives", Lives, 2);
        repeat (60) step();
        chk("c1_wait_caught", Caught, 0);
        chk("c1_wait_lives", Lives, 2);
        step();
        chk("c2_caught", Caught, 1);
        chk("c2_lives", Lives, 1);
        chk("c2_over", Over, 0);
        repeat (60) step();
        step();
        chk("c3_caught", Caught, 1);
        chk("c3_lives", Lives, 0);
        chk("c3_over", Over, 1);
        repeat (3) step();
        chk("over_no_pulse", Caught, 0);
        chk("over_held", Over, 1);
        chk("over_lives", Lives, 0);
        keycode = 8'h28;
        step();
        chk("enter_lives", Lives, 3);
        chk("enter_over", Over, 0);
        chk("enter_x", BallX, 320);
        chk("enter_y", BallY, 240);
        keycode = 8'h00;
        ghost_far();

        // Async reset mid-freeze with timer at 30
        do_reset();
        GhostX = 10'd320;
        GhostY = 10'd240;
        step();
        chk("ar_caught", Caught, 1);
        Start_X = 10'd300;
        repeat (29) step();
        chk("ar_lives_before", Lives, 2);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("ar_x", BallX, 300);
        chk("ar_y", BallY, 240);
        chk("ar_lives", Lives, 3);
        chk("ar_over", Over, 0);
        ghost_far();
        #2;
        Reset_n = 1'b1;
        keycode = 8'h07;
        step();
        step();
        chk("ar_resume_x", BallX, 301);
        chk("ar_resume_lives", Lives, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pacman_player.md
# pacman_player

Player-side counterpart to the ghost chaser. It turns keyboard keycodes into a one-step-per-frame player position (`BallX`/`BallY`/`BallS`), which the ghost logic reads as its target. It detects capture against the ghost position and size, and tracks lives. It drives the `Over` flag that freezes the ghosts and the rest of the game. It sits between the keyboard interface and the ghost/colour-mapper logic, clocked by the frame clock.

## Interface
Parameters:
- `X_MIN`, default 0: left playfield limit.
- `X_MAX`, default 639: right playfield limit.
- `Y_MIN`, default 0: top playfield limit.
- `Y_MAX`, default 479: bottom playfield limit.
- `STEP`, default 1: pixels moved per frame.
- `BALL_SIZE`, default 8: player half-size, driven on `BallS`.
- `LIVES_INIT`, default 3: lives after reset or restart (1..3).
- `FREEZE_FRAMES`, default 60: frames of freeze after a capture.

Ports:
- `frame_clk`, in, 1: the only clock; one rising edge per video frame.
- `Reset_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `keycode`, in, 8: current USB HID keycode; 0 means no key.
- `Start_X`, `Start_Y`, in, 10 each: spawn centre.
- `GhostX`, `GhostY`, in, 10 each: ghost centre.
- `GhostS`, in, 10: ghost size.
- `BallX`, `BallY`, out, 10 each: player centre.
- `BallS`, out, 10: constant `BALL_SIZE`.
- `Over`, out, 1: game over; feeds the ghost `Over` input.
- `Lives`, out, 2: remaining lives.
- `Caught`, out, 1: one-frame pulse on each capture.

## Operation
Direction decode:
- Keycodes map to directions: 0x04 (A) → LEFT, 0x07 (D) → RIGHT, 0x1A (W) → UP, 0x16 (S) → DOWN.
- Directions use the one-hot encoding shared with the ghost logic: LEFT=0001, RIGHT=0010, UP=0100, DOWN=1000, NONE=0000.
- The direction is registered and persists when no key is pressed. Any other keycode is ignored.

Movement, PLAY state only:
- The position moves `STEP` in the current direction when the move keeps the sprite inside the limits:
  - RIGHT: `BallX+BALL_SIZE+STEP <= X_MAX`.
  - LEFT: `BallX >= X_MIN+BALL_SIZE+STEP`.
  - DOWN and UP: same rules on Y.
- Otherwise the position holds and the direction is kept.
- Bounds arithmetic is done in 11-bit unsigned, so there is no wrap-around.

Capture:
- `hit` = `|BallX-GhostX| < (BALL_SIZE+GhostS)>>1` AND `|BallY-GhostY| < (BALL_SIZE+GhostS)>>1`.
- All operands are 11-bit unsigned and are taken from the registered values of the current frame.

State machine:
- PLAY:
  - `hit` with `Lives>1`: go to CAUGHT. `Lives`−1, timer ← `FREEZE_FRAMES`−1, position ← Start, direction ← NONE, `Caught`=1.
  - `hit` with `Lives==1`: go to OVER. `Lives` ← 0, `Caught`=1.
  - `hit` has priority over a movement or key on the same edge. The position does not move on that edge.
- CAUGHT:
  - Position frozen at Start; keys ignored; `hit` ignored.
  - Timer decrements each frame. When timer==0, go to PLAY.
- OVER:
  - `Over`=1; position frozen; `hit` ignored.
  - Keycode 0x28 (Enter): go to PLAY. `Lives` ← `LIVES_INIT`, position ← Start, direction ← NONE.

## Timing
- Reset values: `BallX`=`Start_X`, `BallY`=`Start_Y`, state PLAY, direction NONE, `Lives`=`LIVES_INIT`, `Over`=0, `Caught`=0, timer 0. `BallS`=`BALL_SIZE` at all times.
- Reset asserted mid-CAUGHT or mid-OVER returns immediately to the reset values.
- All outputs are registered.
- Key latency:
  - A key sampled at edge N updates the direction at edge N.
  - The first moved position appears after edge N+1.
- Capture latency: an overlap in frame N produces `Caught`, the `Lives` update and the Start position after edge N+1.
- `Over` rises on the same edge as the final `Caught` pulse.
- The CAUGHT freeze lasts exactly `FREEZE_FRAMES` frames. Movement resumes on the next frame after that.
- Changing `Start_X`/`Start_Y` takes effect only at the next respawn or reset.

## Structure
- Package `pacman_pkg` holds:
  - `dir_t` with the one-hot values, shared with the ghost direction logic;
  - `state_t` (PLAY, CAUGHT, OVER);
  - the keycode constants KEY_A, KEY_D, KEY_W, KEY_S, KEY_ENTER.
- One combinational sub-module, `pacman_collide`: takes the two centres and sizes and produces `hit` via absolute differences. It is reusable for ghost-to-ghost checks.

## Test plan
- Reset with Start=(320,240) → outputs (320,240), `Lives`=3, `Over`=0. Press D (0x07) for 10 frames → `BallX`=329 after the 10th edge (one-frame latency). Release the key, run 5 more frames → `BallX`=334 (direction persists).
- Start=(630,240), hold D → `BallX` stops at 631 (631+8=639). No wrap, no overshoot.
- Ghost at (322,243), player at (320,240), `GhostS`=16 → one `Caught` pulse, `Lives`=2, player at Start. It stays there for 60 frames despite keys, then moves on the 61st.
- Three captures with `LIVES_INIT`=3 → `Lives` 2, 1, 0. `Over`=1 together with the third `Caught`. Further overlaps produce no pulse. Enter (0x28) → `Lives`=3, `Over`=0, player at Start.
- Pull `Reset_n` low asynchronously, between clock edges, while CAUGHT with the timer at 30 → outputs return to reset values before the next edge. After release, PLAY resumes with `Lives`=3.
- Unknown keycode 0x2C while moving UP → UP continues. Same-edge D press and capture → capture wins, and direction is NONE after respawn.
